// File: rtl/io_port_controller.sv
// io_port_controller: memory-mapped I/O port at CPU address 255.
// CPU stores go through a TX FIFO to the device; device words go through an
// RX FIFO to CPU loads. A status word reports occupancy and sticky errors.
//
// Handshake rule for both device-side ports: a word moves on a rising clock
// edge exactly when valid and ready are both 1 in the cycle before that edge.
// valid never waits on ready, and data is held stable while valid && !ready.
module io_port_controller #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter logic [WIDTH-1:0] EMPTY_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_wr_en,
    input  logic [WIDTH-1:0] io_wr_data,
    input  logic             io_rd_en,
    output logic [WIDTH-1:0] io_rd_data,
    input  logic             status_clr,
    output logic [WIDTH-1:0] io_status,
    output logic [WIDTH-1:0] ext_out_data,
    output logic             ext_out_valid,
    input  logic             ext_out_ready,
    input  logic [WIDTH-1:0] ext_in_data,
    input  logic             ext_in_valid,
    output logic             ext_in_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // TX FIFO state
    logic [WIDTH-1:0] tx_mem [DEPTH];
    logic [AW-1:0]    tx_wr_ptr;
    logic [AW-1:0]    tx_rd_ptr;
    logic [CW-1:0]    tx_count;

    // RX FIFO state
    logic [WIDTH-1:0] rx_mem [DEPTH];
    logic [AW-1:0]    rx_wr_ptr;
    logic [AW-1:0]    rx_rd_ptr;
    logic [CW-1:0]    rx_count;

    // Sticky error flags
    logic tx_overflow;
    logic rx_underflow;

    // Derived occupancy and transfer strobes
    logic tx_full;
    logic tx_empty;
    logic rx_full;
    logic rx_empty;
    logic tx_push;
    logic tx_pop;
    logic tx_drop;
    logic rx_push;
    logic rx_pop;
    logic rx_miss;

    assign tx_full  = (tx_count == FULL_COUNT);
    assign tx_empty = (tx_count == '0);
    assign rx_full  = (rx_count == FULL_COUNT);
    assign rx_empty = (rx_count == '0);

    // A full TX FIFO still takes a store when the head leaves on the same edge.
    assign tx_pop  = ext_out_valid && ext_out_ready;
    assign tx_push = io_wr_en && (!tx_full || tx_pop);
    assign tx_drop = io_wr_en && tx_full && !tx_pop;

    // ext_in_ready depends only on rx_full, so a CPU pop never frees a slot
    // for the device within the same cycle.
    assign rx_push = ext_in_valid && ext_in_ready;
    assign rx_pop  = io_rd_en && !rx_empty;
    assign rx_miss = io_rd_en && rx_empty;

    // Outputs are functions of registered state only.
    assign ext_out_valid = !tx_empty;
    assign ext_out_data  = tx_mem[tx_rd_ptr];
    assign ext_in_ready  = !rx_full;
    assign io_rd_data    = rx_empty ? EMPTY_VALUE : rx_mem[rx_rd_ptr];
    assign io_status     = {{(WIDTH-4){1'b0}}, rx_underflow, tx_overflow, !rx_empty, tx_full};

    // TX storage write; contents need no reset because count gates visibility
    always_ff @(posedge clock) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= io_wr_data;
        end
    end

    // RX storage write
    always_ff @(posedge clock) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= ext_in_data;
        end
    end

    // TX pointers and count
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) begin
                tx_wr_ptr <= tx_wr_ptr + AW'(1);
            end
            if (tx_pop) begin
                tx_rd_ptr <= tx_rd_ptr + AW'(1);
            end
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + CW'(1);
                2'b01:   tx_count <= tx_count - CW'(1);
                default: tx_count <= tx_count;
            endcase
        end
    end

    // RX pointers and count
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) begin
                rx_wr_ptr <= rx_wr_ptr + AW'(1);
            end
            if (rx_pop) begin
                rx_rd_ptr <= rx_rd_ptr + AW'(1);
            end
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + CW'(1);
                2'b01:   rx_count <= rx_count - CW'(1);
                default: rx_count <= rx_count;
            endcase
        end
    end

    // Sticky flags: a new error on the same edge as status_clr keeps the flag set
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_overflow  <= 1'b0;
            rx_underflow <= 1'b0;
        end else begin
            tx_overflow  <= (tx_overflow && !status_clr) || tx_drop;
            rx_underflow <= (rx_underflow && !status_clr) || rx_miss;
        end
    end

endmodule

// File: tb/tb_io_port_controller.sv
// Bench for io_port_controller: queue-based reference of both FIFOs and the
// sticky flags, directed scenarios followed by a random mix.
module tb_io_port_controller;

  localparam int W = 16;
  localparam int DEPTH = 4;
  localparam logic [W-1:0] EMPTY_VALUE = 16'h0000;

  logic         clock;
  logic         reset;
  logic         io_wr_en;
  logic [W-1:0] io_wr_data;
  logic         io_rd_en;
  logic [W-1:0] io_rd_data;
  logic         status_clr;
  logic [W-1:0] io_status;
  logic [W-1:0] ext_out_data;
  logic         ext_out_valid;
  logic         ext_out_ready;
  logic [W-1:0] ext_in_data;
  logic         ext_in_valid;
  logic         ext_in_ready;

  io_port_controller #(
    .WIDTH(W),
    .DEPTH(DEPTH),
    .EMPTY_VALUE(EMPTY_VALUE)
  ) dut (
    .clock(clock),
    .reset(reset),
    .io_wr_en(io_wr_en),
    .io_wr_data(io_wr_data),
    .io_rd_en(io_rd_en),
    .io_rd_data(io_rd_data),
    .status_clr(status_clr),
    .io_status(io_status),
    .ext_out_data(ext_out_data),
    .ext_out_valid(ext_out_valid),
    .ext_out_ready(ext_out_ready),
    .ext_in_data(ext_in_data),
    .ext_in_valid(ext_in_valid),
    .ext_in_ready(ext_in_ready)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // scoreboard: words expected to leave each FIFO, plus flag model
  logic [W-1:0] tx_exp_q[$];
  logic [W-1:0] rx_exp_q[$];
  logic         ovf_m;
  logic         unf_m;
  int           total;
  int           bad;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] exp_status();
    logic tx_full_m;
    logic rx_ne_m;
    tx_full_m = (tx_exp_q.size() == DEPTH);
    rx_ne_m   = (rx_exp_q.size() != 0);
    return {12'h000, unf_m, ovf_m, rx_ne_m, tx_full_m};
  endfunction

  // One clock: compare outputs at the falling edge, advance the model for the
  // rising edge, then release the one-cycle pulses just after it.
  task automatic cycle();
    logic tx_pop_m;
    logic tx_full_m;
    logic rx_push_m;
    logic rx_ne_m;
    logic ovf_evt;
    logic unf_evt;
    @(negedge clock);
    check("tx_valid", W'(ext_out_valid), W'(tx_exp_q.size() != 0));
    if (tx_exp_q.size() != 0) check("tx_data", ext_out_data, tx_exp_q[0]);
    check("in_ready", W'(ext_in_ready), W'(rx_exp_q.size() < DEPTH));
    check("rd_data", io_rd_data, (rx_exp_q.size() != 0) ? rx_exp_q[0] : EMPTY_VALUE);
    check("status", io_status, exp_status());

    tx_full_m = (tx_exp_q.size() == DEPTH);
    tx_pop_m  = (tx_exp_q.size() != 0) && ext_out_ready;
    ovf_evt   = io_wr_en && tx_full_m && !tx_pop_m;
    if (tx_pop_m) void'(tx_exp_q.pop_front());
    if (io_wr_en && !ovf_evt) tx_exp_q.push_back(io_wr_data);

    rx_push_m = ext_in_valid && (rx_exp_q.size() < DEPTH);
    rx_ne_m   = (rx_exp_q.size() != 0);
    unf_evt   = io_rd_en && !rx_ne_m;
    if (io_rd_en && rx_ne_m) void'(rx_exp_q.pop_front());
    if (rx_push_m) rx_exp_q.push_back(ext_in_data);

    ovf_m = (ovf_m && !status_clr) || ovf_evt;
    unf_m = (unf_m && !status_clr) || unf_evt;

    @(posedge clock);
    #1;
    io_wr_en   = 1'b0;
    io_rd_en   = 1'b0;
    status_clr = 1'b0;
  endtask

  // driver tasks
  task automatic push_tx(input logic [W-1:0] d);
    io_wr_en   = 1'b1;
    io_wr_data = d;
    cycle();
  endtask

  task automatic send_rx(input logic [W-1:0] d);
    ext_in_valid = 1'b1;
    ext_in_data  = d;
    cycle();
    ext_in_valid = 1'b0;
  endtask

  task automatic cpu_read();
    io_rd_en = 1'b1;
    cycle();
  endtask

  task automatic clear_model();
    tx_exp_q.delete();
    rx_exp_q.delete();
    ovf_m = 1'b0;
    unf_m = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    io_wr_en = 1'b0;
    io_wr_data = '0;
    io_rd_en = 1'b0;
    status_clr = 1'b0;
    ext_out_ready = 1'b0;
    ext_in_data = '0;
    ext_in_valid = 1'b0;
    clear_model();
    reset = 1'b0;
    #12;
    check("rst_valid", W'(ext_out_valid), '0);
    check("rst_ready", W'(ext_in_ready), W'(1));
    check("rst_rd", io_rd_data, EMPTY_VALUE);
    check("rst_status", io_status, 16'h0000);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // two words held back, then drained back to back
    ext_out_ready = 1'b0;
    push_tx(16'hA5A5);
    push_tx(16'h1234);
    cycle();
    check("hold_a5", ext_out_data, 16'hA5A5);
    ext_out_ready = 1'b1;
    check("first_a5", ext_out_data, 16'hA5A5);
    cycle();
    check("second_12", ext_out_data, 16'h1234);
    cycle();
    check("drained", W'(ext_out_valid), '0);
    cycle();

    // overflow: five stores into four slots
    ext_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_tx(W'(16'h0100 + i));
    check("ovf_status", io_status, 16'h0005);
    status_clr = 1'b1;
    cycle();
    check("clr_status", io_status, 16'h0001);
    ext_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    ext_out_ready = 1'b0;

    // device words read back by the CPU
    send_rx(16'h00FF);
    send_rx(16'h0042);
    check("rx_head", io_rd_data, 16'h00FF);
    cpu_read();
    check("rx_next", io_rd_data, 16'h0042);
    cpu_read();
    check("rx_empty", io_rd_data, EMPTY_VALUE);

    // underflow
    cpu_read();
    check("unf_data", io_rd_data, 16'h0000);
    check("unf_status", io_status, 16'h0008);
    status_clr = 1'b1;
    io_rd_en = 1'b1;
    cycle();
    check("clr_vs_set", io_status, 16'h0008);
    status_clr = 1'b1;
    cycle();

    // full FIFO with a push and a pop on every edge
    for (int i = 0; i < DEPTH; i++) push_tx(W'(16'h2000 + i));
    ext_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_tx(W'(16'h3000 + i));
      check("stay_full", io_status, 16'h0001);
    end
    for (int i = 0; i < DEPTH + 1; i++) cycle();
    ext_out_ready = 1'b0;

    // asynchronous reset with three TX words queued
    for (int i = 0; i < 3; i++) push_tx(W'(16'h4000 + i));
    send_rx(16'h5555);
    #2;
    reset = 1'b0;
    #1;
    check("mid_valid", W'(ext_out_valid), '0);
    check("mid_status", io_status, 16'h0000);
    check("mid_rd", io_rd_data, EMPTY_VALUE);
    clear_model();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // random mix
    for (int i = 0; i < 400; i++) begin
      io_wr_en      = ($urandom_range(0, 2) != 0);
      io_wr_data    = W'($urandom_range(0, 65535));
      io_rd_en      = ($urandom_range(0, 2) == 0);
      status_clr    = ($urandom_range(0, 9) == 0);
      ext_out_ready = ($urandom_range(0, 1) != 0);
      ext_in_valid  = ($urandom_range(0, 1) != 0);
      ext_in_data   = W'($urandom_range(0, 65535));
      cycle();
    end
    ext_in_valid = 1'b0;
    ext_out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) cycle();
    check("final_tx_empty", W'(ext_out_valid), '0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
